// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - execute/SRAM/write-back/bypass buses of the memory stage
interface mem_stage_if #(
  parameter int EX_TO_MEM_WD = 147,
  parameter int MEM_TO_WB_WD = 136
);
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [31:0]             data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [37:0]             mem_to_id_bus;

  modport master (
    output ex_to_mem_bus,
    output data_sram_rdata,
    input  mem_to_wb_bus,
    input  mem_to_id_bus
  );

  modport slave (
    input  ex_to_mem_bus,
    input  data_sram_rdata,
    output mem_to_wb_bus,
    output mem_to_id_bus
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage: load align/extend, write-back select, load-data hold
module mem_stage #(
  parameter int EX_TO_MEM_WD = 147,
  parameter int MEM_TO_WB_WD = 136,
  parameter int StallBus     = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [StallBus-1:0] stall,
  mem_stage_if.slave          mif
);
  logic [EX_TO_MEM_WD-1:0] bus_r;
  logic                    held;
  logic [31:0]             hold_data;

  logic [65:0] hilo_bus;
  logic [4:0]  mem_op;
  logic [31:0] mem_pc;
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;
  logic [1:0]  off;
  logic [31:0] rd;
  logic [31:0] ld;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] rf_wdata;
  logic        capture;
  logic        unused_stall;

  assign {hilo_bus, mem_op, mem_pc, data_ram_en, data_ram_wen,
          sel_rf_res, rf_we, rf_waddr, ex_result} = bus_r;

  assign off          = ex_result[1:0];
  assign unused_stall = ^{stall[StallBus-1:5], stall[2:0]};

  // SRAM data is only valid in the first cycle; later stalled cycles read the snapshot
  assign rd      = held ? hold_data : mif.data_sram_rdata;
  assign capture = data_ram_en && (data_ram_wen == 4'b0000) && !held;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_r     <= '0;
      held      <= 1'b0;
      hold_data <= 32'h0;
    end else if (flush) begin
      bus_r <= '0;
      held  <= 1'b0;
    end else if (stall[3] && !stall[4]) begin
      bus_r <= '0;
      held  <= 1'b0;
    end else if (!stall[3]) begin
      bus_r <= mif.ex_to_mem_bus;
      held  <= 1'b0;
    end else if (capture) begin
      held      <= 1'b1;
      hold_data <= mif.data_sram_rdata;
    end
  end

  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    ld       = 32'h0;
    case (off)
      2'b00:   byte_sel = rd[7:0];
      2'b01:   byte_sel = rd[15:8];
      2'b10:   byte_sel = rd[23:16];
      default: byte_sel = rd[31:24];
    endcase
    half_sel = off[1] ? rd[31:16] : rd[15:0];
    // misaligned half/word accesses yield 0; the exception is raised elsewhere
    case (mem_op)
      5'b10000: ld = {{24{byte_sel[7]}}, byte_sel};
      5'b01000: ld = {24'h0, byte_sel};
      5'b00100: ld = off[0] ? 32'h0 : {{16{half_sel[15]}}, half_sel};
      5'b00010: ld = off[0] ? 32'h0 : {16'h0, half_sel};
      5'b00001: ld = (off == 2'b00) ? rd : 32'h0;
      default:  ld = 32'h0;
    endcase
  end

  assign rf_wdata = sel_rf_res ? ld : ex_result;

  assign mif.mem_to_wb_bus = {hilo_bus, mem_pc, rf_we, rf_waddr, rf_wdata};
  assign mif.mem_to_id_bus = {rf_we, rf_waddr, rf_wdata};
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with directed load/stall/flush vectors
module tb_mem_stage;
  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [5:0] stall;

  int checks = 0;
  int errors = 0;

  logic [135:0] exp_q[$];
  string        tag_q[$];

  mem_stage_if #(.EX_TO_MEM_WD(147), .MEM_TO_WB_WD(136)) mif ();

  mem_stage #(.EX_TO_MEM_WD(147), .MEM_TO_WB_WD(136), .StallBus(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .stall (stall),
    .mif   (mif.slave)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] OP_LB  = 5'b10000;
  localparam logic [4:0] OP_LBU = 5'b01000;
  localparam logic [4:0] OP_LH  = 5'b00100;
  localparam logic [4:0] OP_LHU = 5'b00010;
  localparam logic [4:0] OP_LW  = 5'b00001;
  localparam logic [4:0] OP_NO  = 5'b00000;

  function automatic logic [146:0] mk(input logic [65:0] hilo, input logic [4:0] op,
                                      input logic [31:0] pc, input logic en, input logic sel,
                                      input logic [4:0] wa, input logic [31:0] res);
    return {hilo, op, pc, en, 4'b0000, sel, 1'b1, wa, res};
  endfunction

  function automatic logic [135:0] exp_of(input logic [146:0] instr, input logic [31:0] wdata);
    return {instr[146:81], instr[75:44], instr[37], instr[36:32], wdata};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [135:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic one(input string tag, input logic [146:0] instr,
                     input logic [31:0] rdata, input logic [31:0] wdata);
    mif.ex_to_mem_bus = instr;
    push(tag, exp_of(instr, wdata));
    step();
    mif.data_sram_rdata = rdata;
    mif.ex_to_mem_bus   = '0;
    step();
  endtask

  // monitor: valid output (nonzero pc or rf_we) pops the scoreboard, otherwise must be a clean bubble
  always @(negedge clk) begin
    logic [135:0] e;
    string        t;
    if (mif.mem_to_wb_bus[69:38] != 32'h0 || mif.mem_to_wb_bus[37]) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got wb=%h", mif.mem_to_wb_bus);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (mif.mem_to_wb_bus != e || mif.mem_to_id_bus != e[37:0]) begin
          errors++;
          $display("FAIL %s got wb=%h id=%h expected wb=%h id=%h",
                   t, mif.mem_to_wb_bus, mif.mem_to_id_bus, e, e[37:0]);
        end
      end
    end else begin
      checks++;
      if (mif.mem_to_wb_bus != 136'h0 || mif.mem_to_id_bus != 38'h0) begin
        errors++;
        $display("FAIL bubble_zero got wb=%h id=%h expected 0", mif.mem_to_wb_bus, mif.mem_to_id_bus);
      end
    end
  end

  initial begin
    logic [146:0] a;
    logic [146:0] b;
    rst   = 1'b1;
    flush = 1'b0;
    stall = 6'b0;
    mif.ex_to_mem_bus   = '0;
    mif.data_sram_rdata = 32'h0;
    repeat (2) step();
    rst = 1'b0;
    step();

    one("lw_basic", mk(66'h0, OP_LW, 32'h1000, 1'b1, 1'b1, 5'd5, 32'h100), 32'hDEADBEEF, 32'hDEADBEEF);
    one("lb_off1",  mk(66'h0, OP_LB,  32'h1004, 1'b1, 1'b1, 5'd6, 32'h101), 32'h80F17F02, 32'h0000007F);
    one("lb_off2",  mk(66'h0, OP_LB,  32'h1008, 1'b1, 1'b1, 5'd7, 32'h102), 32'h80F17F02, 32'hFFFFFFF1);
    one("lbu_off3", mk(66'h0, OP_LBU, 32'h100C, 1'b1, 1'b1, 5'd8, 32'h103), 32'h80F17F02, 32'h00000080);
    one("lh_off2",  mk(66'h0, OP_LH,  32'h1010, 1'b1, 1'b1, 5'd9, 32'h102), 32'h80F17F02, 32'hFFFF80F1);
    one("lhu_off0", mk(66'h0, OP_LHU, 32'h1014, 1'b1, 1'b1, 5'd10, 32'h100), 32'h80F17F02, 32'h00007F02);
    one("lh_misal", mk(66'h0, OP_LH,  32'h1018, 1'b1, 1'b1, 5'd11, 32'h101), 32'h80F17F02, 32'h0);
    one("lw_misal", mk(66'h0, OP_LW,  32'h101C, 1'b1, 1'b1, 5'd12, 32'h102), 32'h80F17F02, 32'h0);
    one("alu_pass", mk({1'b1, 1'b1, 32'h1, 32'h2}, OP_NO, 32'h1020, 1'b0, 1'b0, 5'd13, 32'hCAFE0001),
        32'h55555555, 32'hCAFE0001);

    // stalled load: SRAM data changes but the held value must persist
    a = mk(66'h0, OP_LW, 32'h2000, 1'b1, 1'b1, 5'd14, 32'h200);
    b = mk(66'h0, OP_NO, 32'h2004, 1'b0, 1'b0, 5'd15, 32'h77);
    mif.ex_to_mem_bus = a;
    step();
    mif.data_sram_rdata = 32'h12345678;
    mif.ex_to_mem_bus   = b;
    stall = 6'b011000;
    for (int i = 0; i < 4; i++) push($sformatf("stall_hold_%0d", i), exp_of(a, 32'h12345678));
    push("after_release", exp_of(b, 32'h77));
    step();
    mif.data_sram_rdata = 32'hFFFFFFFF;
    step();
    step();
    stall = 6'b0;
    step();
    mif.ex_to_mem_bus = '0;
    step();
    step();

    // bubble: stall[3]=1, stall[4]=0 inserts zeros, incoming bus is not taken
    a = mk(66'h0, OP_LW, 32'h3000, 1'b1, 1'b1, 5'd16, 32'h300);
    b = mk(66'h0, OP_NO, 32'h3004, 1'b0, 1'b0, 5'd17, 32'h99);
    mif.ex_to_mem_bus = a;
    push("pre_bubble", exp_of(a, 32'hA5A5A5A5));
    step();
    mif.data_sram_rdata = 32'hA5A5A5A5;
    mif.ex_to_mem_bus   = b;
    stall = 6'b001000;
    step();
    stall = 6'b0;
    mif.ex_to_mem_bus = '0;
    step();
    step();

    // flush wins over a loading stage
    mif.ex_to_mem_bus = mk(66'h0, OP_LW, 32'h4000, 1'b1, 1'b1, 5'd18, 32'h400);
    flush = 1'b1;
    step();
    flush = 1'b0;
    mif.ex_to_mem_bus = '0;
    step();

    // flush wins over a hold with pending capture
    a = mk(66'h0, OP_LW, 32'h4100, 1'b1, 1'b1, 5'd19, 32'h410);
    mif.ex_to_mem_bus = a;
    push("pre_flush_hold", exp_of(a, 32'h0BADF00D));
    step();
    mif.data_sram_rdata = 32'h0BADF00D;
    mif.ex_to_mem_bus   = '0;
    stall = 6'b011000;
    flush = 1'b1;
    step();
    flush = 1'b0;
    stall = 6'b0;
    checks++;
    if (dut.held !== 1'b0) begin
      errors++;
      $display("FAIL flush_clears_held got %b expected 0", dut.held);
    end
    step();

    // async reset mid-stall discards the held load
    a = mk(66'h0, OP_LW, 32'h5000, 1'b1, 1'b1, 5'd20, 32'h500);
    mif.ex_to_mem_bus = a;
    push("pre_reset_0", exp_of(a, 32'hAABBCCDD));
    push("pre_reset_1", exp_of(a, 32'hAABBCCDD));
    step();
    mif.data_sram_rdata = 32'hAABBCCDD;
    mif.ex_to_mem_bus   = '0;
    stall = 6'b011000;
    step();
    mif.data_sram_rdata = 32'h11111111;
    #6;
    rst = 1'b1;
    #1;
    checks++;
    if (mif.mem_to_wb_bus != 136'h0 || mif.mem_to_id_bus != 38'h0 || dut.held !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got wb=%h id=%h held=%b expected 0",
               mif.mem_to_wb_bus, mif.mem_to_id_bus, dut.held);
    end
    step();
    rst   = 1'b0;
    stall = 6'b0;
    step();
    step();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
